// File: rtl/spi_peripheral.sv
// spi_peripheral: slave-side endpoint for 16-bit, mode-0 (CPOL=0, CPHA=0),
// MSB-first SPI frames. The SPI pins are asynchronous to clk and are
// oversampled through synchronizers. The block shifts a buffered word out on
// miso while it assembles the received word.
//
// Ports:
//   clk, reset          fabric clock and synchronous active-high reset
//   sclk, cs, mosi      asynchronous SPI pins from the master (cs active-low)
//   miso                slave data, 0 whenever no frame is active
//   data_to_tx, tx_load single-cycle strobe that writes the TX buffer
//   tx_ready            TX buffer empty, a load is accepted
//   data_rx, rx_done    last complete received word and its one-cycle pulse
//   frame_error         one-cycle pulse when cs rises mid-frame
//   busy                a frame is in progress
module spi_peripheral #(
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [WORD_BITS-1:0] data_to_tx,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] data_rx,
  output logic                 rx_done,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WORD_BITS) + 1;

  typedef enum logic [1:0] {SYNC_WAIT, IDLE, ACTIVE, TAIL} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
  logic                   sclk_s, cs_s, mosi_s;

  state_t                 state_q;
  logic [WORD_BITS-1:0]   tx_buf_q, tx_sh_q, rx_sh_q, data_rx_q;
  logic                   tx_ready_q, miso_q, done_pend_q, rx_done_q, frame_error_q;
  logic [CNT_W-1:0]       bit_cnt_q;

  logic                   frame_start;
  logic [WORD_BITS-1:0]   tx_word, rx_next;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // An empty buffer at frame start sends an all-zero word.
  assign frame_start = (state_q == IDLE) && cs_fall_q;
  assign tx_word     = tx_ready_q ? '0 : tx_buf_q;
  assign rx_next     = {rx_sh_q[WORD_BITS-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      // cs synchronizer clears to 0 so a real high cs must be seen before
      // the first frame; a frame already running at the pins is never joined.
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b0;
      sclk_rise_q   <= 1'b0;
      sclk_fall_q   <= 1'b0;
      cs_rise_q     <= 1'b0;
      cs_fall_q     <= 1'b0;
      state_q       <= SYNC_WAIT;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      data_rx_q     <= '0;
      done_pend_q   <= 1'b0;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      // Synchronizers, then registered edge events (sync XOR delayed copy).
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      sclk_rise_q <= (sclk_s ^ sclk_prev_q) & sclk_s;
      sclk_fall_q <= (sclk_s ^ sclk_prev_q) & ~sclk_s;
      cs_rise_q   <= (cs_s ^ cs_prev_q) & cs_s;
      cs_fall_q   <= (cs_s ^ cs_prev_q) & ~cs_s;

      rx_done_q     <= done_pend_q;
      done_pend_q   <= 1'b0;
      frame_error_q <= 1'b0;

      // A load on the frame-start cycle wins: the word stays buffered for the
      // next frame while the current frame takes the (empty) buffer.
      if (tx_load && tx_ready_q) begin
        tx_buf_q   <= data_to_tx;
        tx_ready_q <= 1'b0;
      end else if (frame_start) begin
        tx_ready_q <= 1'b1;
      end

      case (state_q)
        SYNC_WAIT: begin
          miso_q <= 1'b0;
          if (cs_s) state_q <= IDLE;
        end
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall_q) begin
            tx_sh_q   <= tx_word;
            miso_q    <= tx_word[WORD_BITS-1];
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise_q) begin
            frame_error_q <= 1'b1;
            miso_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (sclk_rise_q) begin
            rx_sh_q   <= rx_next;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
              data_rx_q   <= rx_next;
              done_pend_q <= 1'b1;
              state_q     <= TAIL;
            end
          end else if (sclk_fall_q) begin
            tx_sh_q <= {tx_sh_q[WORD_BITS-2:0], 1'b0};
            miso_q  <= tx_sh_q[WORD_BITS-2];
          end
        end
        TAIL: begin
          // Extra sclk pulses after the last bit are ignored.
          if (sclk_fall_q) miso_q <= 1'b0;
          if (cs_rise_q) begin
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= SYNC_WAIT;
      endcase
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign data_rx     = data_rx_q;
  assign rx_done     = rx_done_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q == ACTIVE) || (state_q == TAIL);

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a mode-0 SPI master model drives directed frames,
// a cycle-level model of the outputs is checked every clock, and literal
// expectations pin replies, received words and pulse counts.
module tb_spi_peripheral;

  localparam int HALF = 6;   // sclk half period in clk cycles
  localparam int GAP  = 10;  // idle cycles after cs rises
  localparam int LAT  = 4;   // pin edge to acting clock edge (L+1)

  logic        clk = 1'b0;
  logic        reset, sclk, cs, mosi, tx_load;
  logic [15:0] data_to_tx;
  logic        miso, tx_ready, rx_done, frame_error, busy;
  logic [15:0] data_rx;

  spi_peripheral #(.WORD_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .data_to_tx(data_to_tx), .tx_load(tx_load), .tx_ready(tx_ready),
    .data_rx(data_rx), .rx_done(rx_done), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_fe = 0;
  bit run = 1'b0;
  bit synced = 1'b0;

  // Model state and per-cycle schedule of expected events.
  logic        m_ready, m_busy;
  logic [15:0] m_buf, m_rx;
  bit          sched_fs[int];
  bit          sched_end[int];
  bit          sched_done[int];
  bit          sched_fe[int];
  logic [15:0] sched_rxw[int];

  logic        ld_smp, rst_smp;
  logic [15:0] dt_smp;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    ld_smp  <= tx_load;
    dt_smp  <= data_to_tx;
    rst_smp <= reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w);
    tx_load = 1'b1;
    data_to_tx = w;
    tick(1);
    tx_load = 1'b0;
  endtask

  // One master frame. nbits sclk pulses; reset pulsed after bit rst_bit
  // (-1 for none); optional tx_load coinciding with the frame-start cycle.
  task automatic frame(input logic [15:0] w, input int nbits, input int rst_bit,
                       input bit ld_start, input logic [15:0] ld_word,
                       output logic [15:0] got);
    int c;
    bit live;
    live = synced;
    got  = '0;
    mosi = w[15];
    cs   = 1'b0;
    c    = cyc;
    if (live) sched_fs[c + LAT] = 1'b1;
    if (ld_start) begin
      tick(LAT - 1);
      load(ld_word);
      tick(HALF - LAT);
    end else begin
      tick(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      c = cyc;
      if (i < 16) got = {got[14:0], miso};
      else chk("miso_after_last_bit", 32'(miso), 32'(0));
      if (live && i == 15) begin
        sched_rxw[c + LAT]      = w;
        sched_done[c + LAT + 1] = 1'b1;
      end
      tick(HALF);
      sclk = 1'b0;
      mosi = (i + 1 < 16) ? w[14-i] : 1'b0;
      if (i == rst_bit) begin
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        live = 1'b0;
        synced = 1'b0;
        tick(HALF - 2);
      end else begin
        tick(HALF);
      end
    end
    cs = 1'b1;
    c = cyc;
    if (live) begin
      if (nbits < 16) sched_fe[c + LAT] = 1'b1;
      sched_end[c + LAT] = 1'b1;
    end
    synced = 1'b1;
    tick(GAP);
  endtask

  // Compare process: advance the model one clock edge, then check outputs.
  initial begin
    bit fs, upd;
    forever begin
      @(negedge clk);
      if (run) begin
        upd = 1'b0;
        if (rst_smp) begin
          m_ready = 1'b1;
          m_buf   = '0;
          m_busy  = 1'b0;
          m_rx    = '0;
        end else begin
          fs = sched_fs.exists(cyc);
          if (ld_smp && m_ready) begin
            m_buf   = dt_smp;
            m_ready = 1'b0;
          end else if (fs) begin
            m_ready = 1'b1;
          end
          if (fs) m_busy = 1'b1;
          if (sched_end.exists(cyc)) m_busy = 1'b0;
          if (sched_rxw.exists(cyc)) begin
            m_rx = sched_rxw[cyc];
            upd  = 1'b1;
          end
        end
        chk("tx_ready", 32'(tx_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rx_done", 32'(rx_done), 32'(sched_done.exists(cyc)));
        chk("frame_error", 32'(frame_error), 32'(sched_fe.exists(cyc)));
        if (!upd) chk("data_rx", 32'(data_rx), 32'(m_rx));
        if (!m_busy) chk("miso_idle", 32'(miso), 32'(0));
        if (rx_done === 1'b1) n_done++;
        if (frame_error === 1'b1) n_fe++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] got;
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; data_to_tx = '0;
    tick(3);
    reset = 1'b0;
    m_ready = 1'b1; m_buf = '0; m_busy = 1'b0; m_rx = '0;
    run = 1'b1;
    chk("reset_miso", 32'(miso), 32'(0));
    chk("reset_data_rx", 32'(data_rx), 32'(0));
    chk("reset_tx_ready", 32'(tx_ready), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_rx_done", 32'(rx_done), 32'(0));
    chk("reset_frame_error", 32'(frame_error), 32'(0));
    tick(6);
    synced = 1'b1;

    // Basic frame
    load(16'hA55A);
    chk("basic_tx_ready_after_load", 32'(tx_ready), 32'(0));
    frame(16'h1234, 16, -1, 1'b0, 16'h0, got);
    chk("basic_reply", 32'(got), 32'(16'hA55A));
    chk("basic_data_rx", 32'(data_rx), 32'(16'h1234));
    chk("basic_done_count", 32'(n_done), 32'(1));
    chk("basic_tx_ready_after", 32'(tx_ready), 32'(1));

    // Back-to-back with underrun on the second frame
    load(16'h00C3);
    frame(16'h0001, 16, -1, 1'b0, 16'h0, got);
    chk("b2b_reply1", 32'(got), 32'(16'h00C3));
    chk("b2b_data_rx1", 32'(data_rx), 32'(16'h0001));
    frame(16'h0002, 16, -1, 1'b0, 16'h0, got);
    chk("b2b_reply2_underrun", 32'(got), 32'(16'h0000));
    chk("b2b_data_rx2", 32'(data_rx), 32'(16'h0002));
    chk("b2b_done_count", 32'(n_done), 32'(3));

    // Early cs rise after 9 bits, then a full frame
    frame(16'hFFFF, 9, -1, 1'b0, 16'h0, got);
    chk("early_fe_count", 32'(n_fe), 32'(1));
    chk("early_done_count", 32'(n_done), 32'(3));
    chk("early_data_rx_held", 32'(data_rx), 32'(16'h0002));
    frame(16'h5A5A, 16, -1, 1'b0, 16'h0, got);
    chk("early_next_data_rx", 32'(data_rx), 32'(16'h5A5A));
    chk("early_next_done_count", 32'(n_done), 32'(4));

    // Load while not ready is ignored; load on the frame-start cycle
    load(16'h1357);
    chk("busyload_tx_ready", 32'(tx_ready), 32'(0));
    load(16'hBEEF);
    frame(16'h0F0F, 16, -1, 1'b0, 16'h0, got);
    chk("busyload_reply", 32'(got), 32'(16'h1357));
    frame(16'h2468, 16, -1, 1'b1, 16'hCAFE, got);
    chk("startload_reply_now", 32'(got), 32'(16'h0000));
    chk("startload_tx_ready", 32'(tx_ready), 32'(0));
    frame(16'h1122, 16, -1, 1'b0, 16'h0, got);
    chk("startload_reply_next", 32'(got), 32'(16'hCAFE));
    chk("startload_data_rx", 32'(data_rx), 32'(16'h1122));
    chk("startload_done_count", 32'(n_done), 32'(7));

    // Reset mid-frame, then a full frame
    frame(16'h3C3C, 16, 5, 1'b0, 16'h0, got);
    chk("midreset_done_count", 32'(n_done), 32'(7));
    chk("midreset_fe_count", 32'(n_fe), 32'(1));
    chk("midreset_data_rx", 32'(data_rx), 32'(0));
    chk("midreset_tx_ready", 32'(tx_ready), 32'(1));
    frame(16'hC3C3, 16, -1, 1'b0, 16'h0, got);
    chk("midreset_next_reply", 32'(got), 32'(16'h0000));
    chk("midreset_next_data_rx", 32'(data_rx), 32'(16'hC3C3));
    chk("midreset_next_done_count", 32'(n_done), 32'(8));

    // 18 sclk pulses in one frame
    load(16'h8001);
    frame(16'h9876, 18, -1, 1'b0, 16'h0, got);
    chk("extra_reply", 32'(got), 32'(16'h8001));
    chk("extra_data_rx", 32'(data_rx), 32'(16'h9876));
    chk("extra_done_count", 32'(n_done), 32'(9));
    chk("extra_fe_count", 32'(n_fe), 32'(1));

    tick(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
